// File: rtl/norm_round_pipe.sv
// Two-stage normalize and round-to-nearest-even pipeline stage fed by the
// leading-zero detector; emits packed sign/exponent/fraction plus flags.
module norm_round_pipe #(
  parameter int WIDTH  = 24,
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W+1:0]       in_exp,
  input  logic [WIDTH-1:0]       in_mant,
  input  logic [$clog2(WIDTH):0] in_lz,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [EXP_W-1:0]       out_exp,
  output logic [FRAC_W-1:0]      out_frac,
  output logic [3:0]             out_flags
);

  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(WIDTH) + 1;
  localparam int KW  = FRAC_W + 1;
  localparam int LOW = WIDTH - KW;
  localparam logic [EW:0] EXP_MAX = (EW+1)'((2**EXP_W) - 1);

  if (WIDTH != 24 && WIDTH != 53) begin : g_bad_width
    $error("norm_round_pipe: WIDTH must be 24 or 53");
  end
  if (KW > WIDTH) begin : g_bad_frac
    $error("norm_round_pipe: FRAC_W+1 must not exceed WIDTH");
  end

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q,  s1_sign_d;
  logic [WIDTH-1:0] s1_norm_q,  s1_norm_d;
  logic [EW-1:0]    s1_exp_q,   s1_exp_d;
  logic             s1_zero_q,  s1_zero_d;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_sign_q,  s2_sign_d;
  logic [WIDTH-1:0] s2_norm_q,  s2_norm_d;
  logic [EW-1:0]    s2_exp_q,   s2_exp_d;
  logic             s2_zero_q,  s2_zero_d;

  logic s1_adv, s2_adv, accept;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = rst_n && s1_adv;
    accept   = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_norm_d  = s1_norm_q;
    s1_exp_d   = s1_exp_q;
    s1_zero_d  = s1_zero_q;
    if (s1_adv) s1_valid_d = accept;
    if (accept) begin
      s1_sign_d = in_sign;
      s1_norm_d = in_mant << in_lz;
      s1_exp_d  = in_exp - EW'(in_lz);
      s1_zero_d = (in_lz == LZW'(WIDTH));
    end

    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_norm_d  = s2_norm_q;
    s2_exp_d   = s2_exp_q;
    s2_zero_d  = s2_zero_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d = s1_sign_q;
        s2_norm_d = s1_norm_q;
        s2_exp_d  = s1_exp_q;
        s2_zero_d = s1_zero_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_norm_q  <= '0;
      s1_exp_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_norm_q  <= '0;
      s2_exp_q   <= '0;
      s2_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_norm_q  <= s1_norm_d;
      s1_exp_q   <= s1_exp_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_norm_q  <= s2_norm_d;
      s2_exp_q   <= s2_exp_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  // Guard/sticky extraction depends on how many bits sit below the kept field.
  logic guard, sticky;
  if (LOW >= 2) begin : g_gs_full
    assign guard  = s2_norm_q[LOW-1];
    assign sticky = |s2_norm_q[LOW-2:0];
  end else if (LOW == 1) begin : g_gs_guard
    assign guard  = s2_norm_q[0];
    assign sticky = 1'b0;
  end else begin : g_gs_none
    assign guard  = 1'b0;
    assign sticky = 1'b0;
  end

  logic [KW-1:0] kept;
  logic [KW:0]   rounded;
  logic          round_up, inexact, carry, unused_hidden;
  logic [EW:0]   exp2;
  logic          exp_ovf, exp_unf;

  always_comb begin
    kept          = s2_norm_q[WIDTH-1 -: KW];
    round_up      = guard && (sticky || kept[0]);
    inexact       = guard || sticky;
    rounded       = {1'b0, kept} + (KW+1)'(round_up);
    carry         = rounded[KW];
    unused_hidden = rounded[FRAC_W];
    exp2          = {s2_exp_q[EW-1], s2_exp_q} + (EW+1)'(carry);
    exp_ovf       = !exp2[EW] && (exp2 >= EXP_MAX);
    exp_unf       = exp2[EW] || (exp2 == '0);
  end

  // Outputs are forced to zero whenever stage 2 is empty so reset clears them.
  always_comb begin
    out_valid = s2_valid_q;
    out_sign  = 1'b0;
    out_exp   = '0;
    out_frac  = '0;
    out_flags = '0;
    if (s2_valid_q) begin
      out_sign = s2_sign_q;
      if (s2_zero_q) begin
        out_flags = 4'b0001;
      end else if (exp_ovf) begin
        out_exp   = '1;
        out_flags = 4'b1010;
      end else if (exp_unf) begin
        out_flags = 4'b0111;
      end else begin
        out_exp   = exp2[EXP_W-1:0];
        out_frac  = rounded[FRAC_W-1:0];
        out_flags = {2'b00, inexact, 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_norm_round_pipe.sv
// Directed bench for norm_round_pipe: literal vectors, a spec-level model
// scoreboard checked on every output handshake, backpressure and reset.
module tb_norm_round_pipe;

  localparam int WIDTH  = 24;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 7;
  localparam int NV     = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [23:0] in_mant = '0;
  logic [5:0]  in_lz = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [6:0]  out_frac;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  always #5 clk = ~clk;

  norm_round_pipe #(.WIDTH(WIDTH), .EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_lz(in_lz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac), .out_flags(out_flags)
  );

  typedef struct {
    logic        s;
    int          e;
    logic [23:0] m;
    int          lz;
    logic [19:0] r;
  } vec_t;

  vec_t vecs [NV] = '{
    '{1'b0, 140, 24'h00C000,  8, {1'b0, 8'd132, 7'h40, 4'b0000}},
    '{1'b0, 127, 24'hFF8000,  0, {1'b0, 8'd128, 7'h00, 4'b0010}},
    '{1'b0, 127, 24'hFE8000,  0, {1'b0, 8'd127, 7'h7E, 4'b0010}},
    '{1'b0, 254, 24'hFF8000,  0, {1'b0, 8'hFF,  7'h00, 4'b1010}},
    '{1'b1,   5, 24'h00C000,  8, {1'b1, 8'd0,   7'h00, 4'b0111}},
    '{1'b0, 100, 24'h000000, 24, {1'b0, 8'd0,   7'h00, 4'b0001}},
    '{1'b0, 127, 24'h818001,  0, {1'b0, 8'd127, 7'h02, 4'b0010}},
    '{1'b0, 254, 24'h800000,  0, {1'b0, 8'd254, 7'h00, 4'b0000}},
    '{1'b0,   1, 24'h800000,  0, {1'b0, 8'd1,   7'h00, 4'b0000}},
    '{1'b0,   0, 24'h800000,  0, {1'b0, 8'd0,   7'h00, 4'b0111}},
    '{1'b1, 127, 24'h800001,  0, {1'b1, 8'd127, 7'h00, 4'b0010}},
    '{1'b1,  -2, 24'h400000,  1, {1'b1, 8'd0,   7'h00, 4'b0111}},
    '{1'b0, 255, 24'hFF0000,  0, {1'b0, 8'hFF,  7'h00, 4'b1010}},
    '{1'b1, 200, 24'h000001, 23, {1'b1, 8'd177, 7'h00, 4'b0000}},
    '{1'b0, 130, 24'h7FFFFF,  1, {1'b0, 8'd130, 7'h00, 4'b0010}},
    '{1'b0, 254, 24'h7FC000,  1, {1'b0, 8'd254, 7'h00, 4'b0010}}
  };

  // Value-level model: round by comparing the discarded remainder to one half.
  function automatic logic [19:0] model(input logic s, input int e,
                                        input longint unsigned m, input int lz);
    longint unsigned norm, kept, rem, half;
    int   ex;
    logic inex;
    if (lz == WIDTH) return {s, 8'd0, 7'd0, 4'b0001};
    norm = (m << lz) & ((64'd1 << WIDTH) - 64'd1);
    kept = norm >> (WIDTH - FRAC_W - 1);
    rem  = norm & ((64'd1 << (WIDTH - FRAC_W - 1)) - 64'd1);
    half = 64'd1 << (WIDTH - FRAC_W - 2);
    inex = (rem != 0);
    ex   = e - lz;
    if (rem > half || (rem == half && kept[0])) kept = kept + 1;
    if (kept == (64'd1 << (FRAC_W + 1))) begin
      kept = kept >> 1;
      ex   = ex + 1;
    end
    if (ex >= (1 << EXP_W) - 1) return {s, 8'hFF, 7'd0, 4'b1010};
    if (ex <= 0) return {s, 8'd0, 7'd0, 4'b0111};
    return {s, ex[7:0], kept[6:0], 2'b00, inex, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input int i);
    in_sign = vecs[i].s;
    in_exp  = 10'(vecs[i].e);
    in_mant = vecs[i].m;
    in_lz   = 6'(vecs[i].lz);
  endtask

  function automatic logic [19:0] outs();
    return {out_sign, out_exp, out_frac, out_flags};
  endfunction

  // Scoreboard: record accepts, compare every output handshake, watch stalls.
  logic [19:0] q [$];
  logic [19:0] held = '0;
  bit          stalled = 0;

  always @(negedge clk) begin
    logic [19:0] cur, want;
    cur = outs();
    if (!rst_n) begin
      q.delete();
      stalled = 0;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_reset actual=%0b required=0", in_ready);
      end
    end else begin
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || cur !== held) begin
          errors++;
          $display("FAIL stall_hold actual=%0b/%h required=1/%h", out_valid, cur, held);
        end
      end
      if (out_valid && out_ready) begin
        hs_count++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%h required=none", cur);
        end else begin
          want = q.pop_front();
          if (cur !== want) begin
            errors++;
            $display("FAIL scoreboard actual=%h required=%h", cur, want);
          end
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(in_sign, int'($signed(in_exp)), longint'(in_mant), int'(in_lz)));
      stalled = out_valid && !out_ready;
      held    = cur;
    end
  end

  task automatic send(input int i);
    bit ok;
    ok = 0;
    drive(i);
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (q.size() != 0 || out_valid); k++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic fill_two(output int acc);
    int idx;
    acc = 0;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(idx);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        acc++;
        if (idx < 2) idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int acc, hs0, stale, idx;
    bit found;
    logic [19:0] snap;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'(outs()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      chk($sformatf("model_pin_%0d", i),
          64'(model(vecs[i].s, vecs[i].e, longint'(vecs[i].m), vecs[i].lz)), 64'(vecs[i].r));

    // One beat at a time against literal expectations.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(i);
      found = 0;
      for (int k = 0; k < 3 && !found; k++) begin
        @(negedge clk);
        if (out_valid) found = 1;
        else begin @(posedge clk); #1; end
      end
      chk($sformatf("latency_%0d", i), 64'(found), 64'd1);
      if (found) chk($sformatf("literal_%0d", i), 64'(outs()), 64'(vecs[i].r));
      @(posedge clk); #1;
    end
    drain();

    // Back-to-back stream: one accept per cycle while out_ready is high.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(i);
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("throughput_%0d", i), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: two beats fit, third is refused, outputs hold.
    fill_two(acc);
    chk("bp_accepted", 64'(acc), 64'd2);
    @(negedge clk);
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    snap = outs();
    repeat (3) @(negedge clk);
    chk("bp_hold", 64'(outs()), 64'(snap));
    chk("bp_valid_hold", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    hs0 = hs_count;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("bp_drain_two", 64'(hs_count - hs0), 64'd2);
    @(negedge clk);
    chk("bp_drain_done", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    drain();

    // Mid-stream reset pulse discards both in-flight beats.
    fill_two(acc);
    chk("rst_setup_accepted", 64'(acc), 64'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'(outs()), 64'd0);
    chk("rst_ready_release", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rst_no_stale", 64'(stale), 64'd0);
    @(posedge clk); #1;

    // Random consumer stalls against a held-until-accepted producer.
    idx = 0;
    for (int c = 0; c < 400 && idx < 3 * NV; c++) begin
      drive(idx % NV);
      in_valid  = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stall_all_sent", 64'(idx), 64'(3 * NV));
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
